// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad encoder: FSM states, key codes and the
// matrix key map used by the encoder and the management controller.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      EMIT         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] KEY_NONE  = 4'b0000;
   localparam logic [3:0] KEY_OPEN  = 4'b1010;
   localparam logic [3:0] KEY_ENTER = 4'b1011;
   localparam logic [3:0] KEY_CLOSE = 4'b1100;
   localparam logic [3:0] KEY_EMERG = 4'b1101;

   typedef struct packed {
      logic       assigned;
      logic [3:0] code;
   } key_t;

   // Unassigned positions return code 0000 so they can never reach the output.
   function automatic key_t key_map(input logic [1:0] row, input logic [1:0] col);
      key_t k;
      k.assigned = 1'b1;
      case ({row, col})
         4'h0:    k.code = 4'b0001;
         4'h1:    k.code = 4'b0010;
         4'h2:    k.code = 4'b0011;
         4'h3:    k.code = KEY_OPEN;
         4'h4:    k.code = 4'b0100;
         4'h5:    k.code = 4'b0101;
         4'h6:    k.code = 4'b0110;
         4'h7:    k.code = KEY_CLOSE;
         4'h8:    k.code = 4'b0111;
         4'h9:    k.code = 4'b1000;
         4'hA:    k.code = 4'b1001;
         4'hB:    k.code = KEY_ENTER;
         4'hC:    k.code = KEY_EMERG;
         default: begin
            k.code     = KEY_NONE;
            k.assigned = 1'b0;
         end
      endcase
      return k;
   endfunction

   function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
      if (!cols[0])      return 2'd0;
      else if (!cols[1]) return 2'd1;
      else if (!cols[2]) return 2'd2;
      else               return 2'd3;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Four-bit two-flop synchronizer for the keypad columns; resets to all ones
// so an idle (pulled-up) keypad is seen during and right after reset.
module sync_2ff (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 4'hF;
         q    <= 4'hF;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Scans a 4x4 active-low keypad, debounces press and release, and emits one
// code pulse per physical press on BCD_output.
module keypad_bcd_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic       CLK,
   input  logic       RST,
   output logic [3:0] row_out,
   input  logic [3:0] col_in,
   output logic [3:0] BCD_output,
   output logic       key_valid,
   output state_t     fsm_state
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic [3:0]    col_s;
   logic [SW-1:0] slot;
   logic          sample;

   state_t        state, state_n;
   logic [1:0]    row, row_n;
   logic [DW-1:0] cnt, cnt_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [3:0]    pat, pat_n;
   key_t          key_q, key_n, key_hit;

   sync_2ff u_sync (
      .clk (CLK),
      .rst (RST),
      .d   (col_in),
      .q   (col_s)
   );

   // Slot timing runs freely; the FSM only acts on the last cycle of a slot.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) slot <= '0;
      else     slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
   end

   assign sample  = (slot == SLOT_LAST);
   assign key_hit = key_map(row, lowest_low_col(col_s));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= SCAN;
         row      <= 2'd0;
         cnt      <= '0;
         hold_cnt <= '0;
         pat      <= 4'hF;
         key_q    <= '0;
      end else begin
         state    <= state_n;
         row      <= row_n;
         cnt      <= cnt_n;
         hold_cnt <= hold_n;
         pat      <= pat_n;
         key_q    <= key_n;
      end
   end

   always_comb begin
      state_n = state;
      row_n   = row;
      cnt_n   = cnt;
      hold_n  = hold_cnt;
      pat_n   = pat;
      key_n   = key_q;
      case (state)
         SCAN: begin
            if (sample) begin
               if (&col_s) begin
                  row_n = row + 2'd1;
               end else begin
                  pat_n  = col_s;
                  key_n  = key_hit;
                  hold_n = '0;
                  // The latching sample is the first match.
                  if (DEBOUNCE_CNT == 1) begin
                     cnt_n   = '0;
                     state_n = key_hit.assigned ? EMIT : WAIT_RELEASE;
                  end else begin
                     cnt_n   = DW'(1);
                     state_n = DEBOUNCE;
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (col_s == pat) begin
                  if (cnt == DB_LAST) begin
                     cnt_n   = '0;
                     hold_n  = '0;
                     state_n = key_q.assigned ? EMIT : WAIT_RELEASE;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n   = '0;
                  row_n   = row + 2'd1;
                  state_n = SCAN;
               end
            end
         end
         EMIT: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_n  = '0;
               cnt_n   = '0;
               state_n = WAIT_RELEASE;
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (sample) begin
               if (&col_s) begin
                  if (cnt == DB_LAST) begin
                     cnt_n   = '0;
                     row_n   = 2'd0;
                     state_n = SCAN;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n = '0;
               end
            end
         end
         default: state_n = SCAN;
      endcase
   end

   // Outputs decode the state directly so reset clears them without a clock.
   assign row_out    = ~(4'b0001 << row);
   assign key_valid  = (state == EMIT);
   assign BCD_output = (state == EMIT) ? key_q.code : KEY_NONE;
   assign fsm_state  = state;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Directed bench for keypad_bcd_encoder with a behavioural 4x4 key matrix.
module tb_keypad_bcd_encoder;
   import keypad_pkg::*;

   logic       CLK;
   logic       RST;
   logic [3:0] row_out;
   logic [3:0] col_in;
   logic [3:0] BCD_output;
   logic       key_valid;
   state_t     fsm_state;
   logic [15:0] keys;

   int compared;
   int mismatched;
   int valid_total;
   int inv_err;
   int bad_code;
   int base;

   keypad_bcd_encoder #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .HOLD_CYCLES(1)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .row_out    (row_out),
      .col_in     (col_in),
      .BCD_output (BCD_output),
      .key_valid  (key_valid),
      .fsm_state  (fsm_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // key matrix: a pressed key shorts its column to a driven (low) row
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
   end

   // output monitor
   initial begin
      valid_total = 0;
      inv_err     = 0;
      bad_code    = 0;
   end

   always @(negedge CLK) begin
      if (key_valid) valid_total++;
      if (key_valid !== (BCD_output != 4'b0000)) inv_err++;
      if (BCD_output == 4'b1110 || BCD_output == 4'b1111) bad_code++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Returns one step after the edge that newly selects the target row.
   task automatic wait_row(input logic [3:0] target);
      logic [3:0] prev;
      logic       ok;
      prev = row_out;
      ok   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK);
         #1;
         if (row_out == target && prev != target) begin
            ok = 1'b1;
            break;
         end
         prev = row_out;
      end
      chk("wait_row", 32'(ok), 32'd1);
   endtask

   task automatic wait_scan();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge CLK);
         #1;
         if (fsm_state == SCAN) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_scan", 32'(ok), 32'd1);
   endtask

   // directed stimulus
   initial begin
      logic [3:0] rows [4];
      rows[0] = 4'b1110;
      rows[1] = 4'b1101;
      rows[2] = 4'b1011;
      rows[3] = 4'b0111;
      compared   = 0;
      mismatched = 0;
      keys       = 16'h0000;
      RST        = 1'b1;

      tick(3);
      chk("rst_row", 32'(row_out), 32'h0E);
      chk("rst_bcd", 32'(BCD_output), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_state", 32'(fsm_state), 32'(SCAN));
      @(negedge CLK);
      RST = 1'b0;

      // 1: idle rotation, 4 cycles per row
      base = valid_total;
      for (int k = 0; k < 16; k++) begin
         tick(4);
         chk("idle_row", 32'(row_out), 32'(rows[(k + 1) % 4]));
      end
      chk("idle_no_pulse", 32'(valid_total - base), 32'd0);

      // 2: row 2 / col 3 (enter) held 200 cycles
      wait_row(4'b1011);
      base = valid_total;
      keys[11] = 1'b1;
      tick(11);
      chk("enter_pre", 32'(key_valid), 32'd0);
      tick(1);
      chk("enter_valid", 32'(key_valid), 32'd1);
      chk("enter_code", 32'(BCD_output), 32'hB);
      tick(1);
      chk("enter_end", 32'(key_valid), 32'd0);
      tick(186);
      chk("enter_count", 32'(valid_total - base), 32'd1);
      chk("enter_hold_row", 32'(row_out), 32'h0B);
      chk("enter_hold_state", 32'(fsm_state), 32'(WAIT_RELEASE));
      keys[11] = 1'b0;
      tick(2);
      chk("enter_rel_wait", 32'(fsm_state), 32'(WAIT_RELEASE));
      wait_scan();
      chk("enter_rel_row0", 32'(row_out), 32'h0E);

      // 3: row 0 / col 0 bounce, then stable
      wait_row(4'b1110);
      base = valid_total;
      tick(1);
      keys[0] = 1'b1;
      tick(3);
      keys[0] = 1'b0;
      tick(2);
      keys[0] = 1'b1;
      tick(25);
      chk("bounce_pre", 32'(key_valid), 32'd0);
      chk("bounce_none", 32'(valid_total - base), 32'd0);
      tick(1);
      chk("bounce_valid", 32'(key_valid), 32'd1);
      chk("bounce_code", 32'(BCD_output), 32'h1);
      tick(1);
      chk("bounce_end", 32'(key_valid), 32'd0);
      tick(40);
      chk("bounce_count", 32'(valid_total - base), 32'd1);
      keys[0] = 1'b0;
      wait_scan();

      // 4: two keys in row 1, then a row 0 key while still held
      wait_row(4'b1101);
      base = valid_total;
      keys[4] = 1'b1;
      keys[6] = 1'b1;
      tick(11);
      chk("multi_pre", 32'(key_valid), 32'd0);
      tick(1);
      chk("multi_valid", 32'(key_valid), 32'd1);
      chk("multi_code", 32'(BCD_output), 32'h4);
      tick(1);
      keys[1] = 1'b1;
      tick(60);
      chk("multi_held_count", 32'(valid_total - base), 32'd1);
      chk("multi_held_row", 32'(row_out), 32'h0D);
      keys = 16'h0000;
      wait_scan();
      tick(60);
      chk("multi_rel_count", 32'(valid_total - base), 32'd1);

      // 5: unassigned row 3 / col 2, then emergency row 3 / col 0
      wait_row(4'b0111);
      base = valid_total;
      keys[14] = 1'b1;
      tick(100);
      chk("unassigned_count", 32'(valid_total - base), 32'd0);
      chk("unassigned_state", 32'(fsm_state), 32'(WAIT_RELEASE));
      chk("unassigned_row", 32'(row_out), 32'h07);
      keys[14] = 1'b0;
      wait_scan();
      wait_row(4'b0111);
      base = valid_total;
      keys[12] = 1'b1;
      tick(11);
      chk("emerg_pre", 32'(key_valid), 32'd0);
      tick(1);
      chk("emerg_valid", 32'(key_valid), 32'd1);
      chk("emerg_code", 32'(BCD_output), 32'hD);
      tick(1);
      chk("emerg_end", 32'(key_valid), 32'd0);
      tick(40);
      chk("emerg_count", 32'(valid_total - base), 32'd1);
      keys[12] = 1'b0;
      wait_scan();

      // 6: reset during EMIT of 0101 with the key held
      wait_row(4'b1101);
      keys[5] = 1'b1;
      tick(12);
      chk("rstemit_valid", 32'(key_valid), 32'd1);
      chk("rstemit_code", 32'(BCD_output), 32'h5);
      RST = 1'b1;
      #1;
      chk("rstemit_bcd", 32'(BCD_output), 32'h0);
      chk("rstemit_kv", 32'(key_valid), 32'd0);
      tick(2);
      chk("rstemit_row", 32'(row_out), 32'h0E);
      @(negedge CLK);
      RST = 1'b0;
      base = valid_total;
      tick(15);
      chk("after_rst_pre", 32'(key_valid), 32'd0);
      tick(1);
      chk("after_rst_valid", 32'(key_valid), 32'd1);
      chk("after_rst_code", 32'(BCD_output), 32'h5);
      tick(1);
      chk("after_rst_end", 32'(key_valid), 32'd0);
      tick(40);
      chk("after_rst_count", 32'(valid_total - base), 32'd1);
      keys[5] = 1'b0;
      wait_scan();

      chk("valid_iff_nonzero", 32'(inv_err), 32'd0);
      chk("no_code_e_f", 32'(bad_code), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/keypad_bcd_encoder.md
Name: keypad_bcd_encoder

Overview:
- Scans the elevator's 4x4 matrix keypad, debounces presses and emits one 4-bit code per key press.
- Its output drives the BCD_input port of the management controller; 4'b0000 means no key.
- One code pulse is produced per physical press. There is no auto-repeat.
- A new code is only produced after the previous key has been released.

Parameters:
- SCAN_DIV, 4: clock cycles each row stays driven. Columns are sampled in the last cycle of the slot. Must be at least 3.
- DEBOUNCE_CNT, 3: consecutive matching samples required to accept a press or a release. Must be at least 1.
- HOLD_CYCLES, 1: number of cycles a code stays on BCD_output. Must be at least 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- row_out  out  4  keypad row drive, active-low, one-cold. row_out[r]=0 selects row r.
- col_in  in  4  keypad columns, active-low with external pull-ups. Asynchronous input.
- BCD_output  out  4  key code to management BCD_input. 4'b0000 when idle.
- key_valid  out  1  high exactly while BCD_output is non-zero.

Behaviour:
- Clocking and reset: one clock (CLK); reset is asynchronous and active-high (RST).
- Reset values:
  - row_out=4'b1110 (row 0).
  - BCD_output=4'b0000, key_valid=0.
  - State SCAN; all counters 0; synchronizer flops all 1.
- Input synchronization: col_in passes through a two-flop synchronizer, giving col_s. All decisions use col_s only.
- Key codes:
  - Row 0, cols 0-3: 0001, 0010, 0011, 1010 (door open).
  - Row 1, cols 0-3: 0100, 0101, 0110, 1100 (door close).
  - Row 2, cols 0-3: 0111, 1000, 1001, 1011 (enter).
  - Row 3: col 0 = 1101 (emergency/clear). Cols 1-3 are unassigned.
- Sample point: the last cycle of each SCAN_DIV slot, i.e. slot counter = SCAN_DIV-1.
- SCAN state:
  - At a sample point with col_s all ones, advance to the next row: 0→1→2→3→0.
  - At a sample point with any col_s bit low:
    - latch the row and the full col_s pattern;
    - select the lowest-index low column as the key;
    - go to DEBOUNCE and stop row rotation.
- DEBOUNCE state:
  - The same row stays driven. At each sample point, compare col_s with the latched pattern.
  - On a match, increment the match counter. The latching sample counts as match 1.
  - On a mismatch, return to SCAN at the next row and clear the counter.
  - On reaching DEBOUNCE_CNT matches:
    - an assigned key goes to EMIT in the next cycle;
    - an unassigned key goes directly to WAIT_RELEASE with no pulse.
- EMIT state:
  - BCD_output=code and key_valid=1 for exactly HOLD_CYCLES cycles.
  - Then BCD_output returns to 0000 and the state goes to WAIT_RELEASE.
- WAIT_RELEASE state:
  - The same row stays driven.
  - The block needs DEBOUNCE_CNT consecutive sample points with col_s all ones. Any low sample restarts that count.
  - When the count completes, go to SCAN at row 0.
- Multiple keys:
  - Two keys in the same row: the lowest column wins. Changes in the pattern during debounce cause a mismatch and a restart.
  - Keys in different rows: the first row scanned wins.
  - A key pressed during WAIT_RELEASE is ignored until full release.
- Asynchronous RST in any state, including mid-EMIT:
  - BCD_output forced to 0000 immediately;
  - no partial or extra pulse after RST deasserts.
- Latency from a stable press on the currently driven row: at most 2 (sync) + DEBOUNCE_CNT*SCAN_DIV + 1 cycles to key_valid.
- Codes 1110 and 1111 are never emitted.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE;
  - code constants: KEY_NONE=0000, KEY_OPEN=1010, KEY_ENTER=1011, KEY_CLOSE=1100, KEY_EMERG=1101;
  - the 16-entry key map function (row,col → code, plus an assigned flag).
- The management block imports the same code constants.
- One sub-module, sync_2ff: a 4-bit two-flop synchronizer with asynchronous active-high reset to all ones.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3, HOLD_CYCLES=1.
1. Reset, no keys pressed for 64 cycles → row_out cycles 1110, 1101, 1011, 0111 every 4 cycles; BCD_output=0000 and key_valid=0 throughout.
2. Hold row 2 / col 3 low for 200 cycles, then release → exactly one 1-cycle pulse BCD_output=1011; latency within the stated bound. After release plus 3 clean samples, scanning resumes at row 0.
3. Row 0 / col 0 bounces (low 3 cycles, high 2, low 3) before a stable press → no pulse during the bounce. Exactly one 0001 pulse after 3 stable samples.
4. Row 1 / col 0 and row 1 / col 2 pressed together → one pulse of 0100. Pressing row 0 / col 1 while still holding row 1 produces no pulse until both keys are released.
5. Row 3 / col 2 held (unassigned) → no pulse ever, and key_valid stays 0. Row 3 / col 0 → one 1101 pulse.
6. Assert RST during the EMIT cycle of a 0101 press → BCD_output=0000 immediately. After RST drops with the key still held, exactly one new 0101 pulse appears after the full debounce.
